// File: rtl/rf_pkg.sv
// rf_pkg: shared widths, register-zero constant and writeback entry type for the write arbiter
package rf_pkg;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NUM_REGS = 32;
    localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;
    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_entry_t;
    // One-hot pending bit for a held entry; register 0 never shows as pending.
    function automatic logic [NUM_REGS-1:0] pend_bit(input wb_entry_t e);
        return (e.valid && e.addr != REG_ZERO) ? ({{(NUM_REGS-1){1'b0}}, 1'b1} << e.addr) : '0;
    endfunction
endpackage

// File: rtl/wb_hold_slot.sv
// wb_hold_slot: one-entry writeback holding register with load, drain and drop-on-x0
// Ports: i_clk, i_rst (async, active-high); i_valid/i_addr/i_data offered write;
//        i_grant entry is written this cycle; o_ready slot can accept;
//        o_load a real (non-x0) entry is captured this edge; o_entry held entry.
import rf_pkg::*;
module wb_hold_slot (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_valid,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_grant,
    output logic              o_ready,
    output logic              o_load,
    output wb_entry_t         o_entry
);
    wb_entry_t r_entry;
    logic      w_take;
    // A granted slot drains this edge, so it can take a new entry at the same time.
    assign o_ready = !i_rst && (!r_entry.valid || i_grant);
    assign w_take  = i_valid && o_ready;
    assign o_load  = w_take && (i_addr != REG_ZERO);
    assign o_entry = r_entry;
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_entry <= '0;
        else if (o_load)
            r_entry <= wb_entry_t'{valid: 1'b1, addr: i_addr, data: i_data};
        else if (w_take || i_grant)
            r_entry.valid <= 1'b0;
    end
endmodule

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: shares the register-file write port between ALU (A) and load (B) writeback
// Ports: i_clk, i_reset (async, active-high);
//        i_a_valid/o_a_ready/i_a_addr/i_a_data  source A (execute result);
//        i_b_valid/o_b_ready/i_b_addr/i_b_data  source B (load data);
//        o_rf_writeenable/o_rf_inaddress/o_rf_in  reg_file write port;
//        o_pending_mask  registers targeted by held, not-yet-written entries.
import rf_pkg::*;
module rf_write_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_a_valid,
    output logic                o_a_ready,
    input  logic [ADDR_W-1:0]   i_a_addr,
    input  logic [DATA_W-1:0]   i_a_data,
    input  logic                i_b_valid,
    output logic                o_b_ready,
    input  logic [ADDR_W-1:0]   i_b_addr,
    input  logic [DATA_W-1:0]   i_b_data,
    output logic                o_rf_writeenable,
    output logic [ADDR_W-1:0]   o_rf_inaddress,
    output logic [DATA_W-1:0]   o_rf_in,
    output logic [NUM_REGS-1:0] o_pending_mask
);
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    wb_entry_t      w_a, w_b;
    logic           w_grant_a, w_grant_b, w_load_a, w_load_b, w_held_a, w_held_b;
    logic           r_b_older;
    logic [CNT_W-1:0] r_starve;
    wb_hold_slot u_slot_a (
        .i_clk(i_clk), .i_rst(i_reset), .i_valid(i_a_valid), .i_addr(i_a_addr), .i_data(i_a_data),
        .i_grant(w_grant_a), .o_ready(o_a_ready), .o_load(w_load_a), .o_entry(w_a)
    );
    wb_hold_slot u_slot_b (
        .i_clk(i_clk), .i_rst(i_reset), .i_valid(i_b_valid), .i_addr(i_b_addr), .i_data(i_b_data),
        .i_grant(w_grant_b), .o_ready(o_b_ready), .o_load(w_load_b), .o_entry(w_b)
    );
    // Same destination: oldest first keeps write order; otherwise loads win unless A is starved.
    always_comb begin
        w_grant_a = w_a.valid && (!w_b.valid ||
                    ((w_a.addr == w_b.addr) ? !r_b_older : (r_starve == CNT_W'(STARVE_LIMIT))));
        w_grant_b = w_b.valid && !w_grant_a;
    end
    assign w_held_a = w_a.valid && !w_grant_a;
    assign w_held_b = w_b.valid && !w_grant_b;
    // Age only matters while both slots hold entries; a held entry is older than a refill.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)
            r_b_older <= 1'b0;
        else if (w_load_b && w_held_a)
            r_b_older <= 1'b0;
        else if (w_load_a && (w_load_b || w_held_b))
            r_b_older <= 1'b1;
    end
    // A is held and losing exactly when its slot is valid but not granted.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)
            r_starve <= '0;
        else if (!w_held_a)
            r_starve <= '0;
        else if (r_starve != CNT_W'(STARVE_LIMIT))
            r_starve <= r_starve + 1'b1;
    end
    assign o_rf_writeenable = w_grant_a || w_grant_b;
    assign o_rf_inaddress   = w_grant_a ? w_a.addr : w_grant_b ? w_b.addr : REG_ZERO;
    assign o_rf_in          = w_grant_a ? w_a.data : w_grant_b ? w_b.data : '0;
    assign o_pending_mask   = pend_bit(w_a) | pend_bit(w_b);
endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb_rf_write_arbiter: directed and random checks of rf_write_arbiter against a timestamped slot model
module tb_rf_write_arbiter;
    import rf_pkg::*;
    localparam int L = 4;
    logic        clk = 0, rst = 0;
    logic        a_valid = 0, b_valid = 0, a_ready, b_ready, we;
    logic [4:0]  a_addr = 0, b_addr = 0, waddr;
    logic [31:0] a_data = 0, b_data = 0, wdata, mask;
    always #5 clk = ~clk;
    rf_write_arbiter #(.STARVE_LIMIT(L)) dut (
        .i_clk(clk), .i_reset(rst),
        .i_a_valid(a_valid), .o_a_ready(a_ready), .i_a_addr(a_addr), .i_a_data(a_data),
        .i_b_valid(b_valid), .o_b_ready(b_ready), .i_b_addr(b_addr), .i_b_data(b_data),
        .o_rf_writeenable(we), .o_rf_inaddress(waddr), .o_rf_in(wdata), .o_pending_mask(mask)
    );
    typedef struct {bit v; logic [4:0] a; logic [31:0] d; int t;} mslot_t;
    mslot_t ma, mb;
    int mstarve = 0, cyc = 0, errors = 0, checks = 0, found;
    bit last_acc_a, last_acc_b;
    logic [31:0] dut_rf [32];
    always @(posedge clk) if (we) dut_rf[waddr] <= wdata;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic model_reset();
        ma.v = 0; mb.v = 0; mstarve = 0;
    endtask
    // Check outputs against the model for the current cycle, then advance the model over the edge.
    task automatic tick();
        bit ga, gb, ra, rb, acc_a, acc_b;
        logic [31:0] m;
        #1;
        ga = 0; gb = 0;
        if (ma.v && mb.v) begin
            ga = (ma.a == mb.a) ? (ma.t < mb.t) : (mstarve >= L);
            gb = !ga;
        end else begin
            ga = ma.v; gb = mb.v;
        end
        ra = !ma.v || ga; rb = !mb.v || gb;
        m = 0;
        if (ma.v) m[ma.a] = 1'b1;
        if (mb.v) m[mb.a] = 1'b1;
        chk("a_ready", a_ready, ra);
        chk("b_ready", b_ready, rb);
        chk("we", we, ga || gb);
        chk("waddr", waddr, ga ? ma.a : gb ? mb.a : 5'd0);
        chk("wdata", wdata, ga ? ma.d : gb ? mb.d : 32'd0);
        chk("mask", mask, m);
        @(posedge clk);
        cyc++;
        mstarve = (ma.v && mb.v && !ga) ? ((mstarve < L) ? mstarve + 1 : L) : 0;
        acc_a = a_valid && ra; acc_b = b_valid && rb;
        if (acc_a) begin
            if (a_addr != 0) ma = '{1'b1, a_addr, a_data, 2 * cyc + 1}; else ma.v = 0;
        end else if (ga) ma.v = 0;
        if (acc_b) begin
            if (b_addr != 0) mb = '{1'b1, b_addr, b_data, 2 * cyc}; else mb.v = 0;
        end else if (gb) mb.v = 0;
        last_acc_a = acc_a; last_acc_b = acc_b;
        @(negedge clk);
    endtask
    task automatic chk_zero(input string tag);
        chk({tag, "_we"}, we, 0);
        chk({tag, "_addr"}, waddr, 0);
        chk({tag, "_data"}, wdata, 0);
        chk({tag, "_mask"}, mask, 0);
        chk({tag, "_ardy"}, a_ready, 0);
        chk({tag, "_brdy"}, b_ready, 0);
    endtask
    initial begin
        for (int i = 0; i < 32; i++) dut_rf[i] = 0;
        model_reset();
        #1 rst = 1;
        #1 chk_zero("rst");
        @(negedge clk); rst = 0;
        // 1: single A write
        a_valid = 1; a_addr = 5; a_data = 32'hDEADBEEF; tick();
        a_valid = 0;
        #1 chk("t1_we", we, 1); chk("t1_addr", waddr, 5); chk("t1_data", wdata, 32'hDEADBEEF); chk("t1_mask", mask, 32'h20);
        tick();
        #1 chk("t1_mask_clr", mask, 0); chk("t1_we_clr", we, 0);
        // 2: A and B on the same edge, B first
        a_valid = 1; a_addr = 3; a_data = 32'h33; b_valid = 1; b_addr = 4; b_data = 32'h44; tick();
        a_valid = 0; b_valid = 0;
        #1 chk("t2_first", waddr, 4); chk("t2_a_rdy", a_ready, 0);
        tick();
        #1 chk("t2_second", waddr, 3);
        tick();
        // 3: same destination, A then B
        a_valid = 1; a_addr = 7; a_data = 32'h1; tick();
        a_valid = 0; b_valid = 1; b_addr = 7; b_data = 32'h2; tick();
        b_valid = 0; tick(); tick();
        chk("t3_r7", dut_rf[7], 32'h2);
        // 4: starvation of A
        a_valid = 1; a_addr = 9; a_data = 32'h99; b_valid = 1; b_addr = 10; b_data = $urandom; tick();
        a_valid = 0; found = 0;
        for (int k = 1; k <= 10 && found == 0; k++) begin
            if (last_acc_b) begin b_addr = 5'(10 + k); b_data = $urandom; end
            #1 if (we && waddr == 9) found = k;
            tick();
        end
        chk("t4_starve_cycle", found, 5);
        b_valid = 0; tick(); tick();
        // 5: address 0 on both sources
        a_valid = 1; a_addr = 0; a_data = 32'hA0; b_valid = 1; b_addr = 0; b_data = 32'hB0; tick();
        chk("t5_acc", {last_acc_a, last_acc_b}, 2'b11);
        a_valid = 0; b_valid = 0;
        #1 chk("t5_we", we, 0); chk("t5_mask", mask, 0);
        tick();
        // 6: reset while both slots hold entries
        a_valid = 1; a_addr = 3; a_data = 32'h55; b_valid = 1; b_addr = 4; b_data = 32'h66; tick();
        a_valid = 0; b_valid = 0;
        #2 rst = 1;
        #1 chk_zero("t6");
        model_reset();
        @(posedge clk); @(negedge clk); rst = 0;
        #1 chk("t6_ardy", a_ready, 1); chk("t6_brdy", b_ready, 1); chk("t6_we", we, 0);
        tick(); tick();
        chk("t6_nowrite", dut_rf[4], 32'h44);
        // random traffic with small address range to force collisions and x0 drops
        last_acc_a = 1; last_acc_b = 1;
        for (int n = 0; n < 400; n++) begin
            if (n == 200) begin
                rst = 1; a_valid = 0; b_valid = 0;
                #1 chk_zero("rnd_rst");
                model_reset();
                @(posedge clk); @(negedge clk); rst = 0;
                last_acc_a = 1; last_acc_b = 1;
            end
            if (!a_valid || last_acc_a) begin
                a_valid = $urandom_range(0, 99) < 60; a_addr = 5'($urandom_range(0, 7)); a_data = $urandom;
            end
            if (!b_valid || last_acc_b) begin
                b_valid = $urandom_range(0, 99) < 70; b_addr = 5'($urandom_range(0, 7)); b_data = $urandom;
            end
            tick();
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
